// File: rtl/alu_core.sv
// alu_core: sequential execute unit of the KGP-RISC datapath.
// Add/sub/logic/compare finish in one cycle; shifts move one bit per
// clock. Result and flags are registered together and held until the
// next completion, which is announced by a one-cycle done pulse.
//
// Handshake: a request is taken on any rising edge where start=1 and
// busy=0 (the acceptance edge). Operands and opcode are consumed on that
// edge only; start while busy=1 is dropped, never queued. Every accepted
// request yields exactly one done pulse unless reset intervenes. busy is
// low in the done cycle, so start held in that cycle is accepted
// immediately (back-to-back issue).
module alu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] inp1,
    input  logic [31:0] inp2,
    output logic [31:0] result,
    output logic        zero,
    output logic        sign,
    output logic        carry,
    output logic        overflow,
    output logic        busy,
    output logic        done,
    output logic        dbg_state
);

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_COMP,
        OP_AND,
        OP_XOR,
        OP_SLT,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_NULL
    } op_t;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } shift_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t      r_state;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_sign;
    logic        r_carry;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_shreg;
    logic [4:0]  r_cnt;
    shift_t      r_sh_type;

    op_t         w_op;
    logic [4:0]  w_shamt;
    logic        w_is_shift;
    logic        w_start_shift;
    shift_t      w_sh_type;
    logic [31:0] w_neg_b;
    logic [32:0] w_add_sum;
    logic [31:0] w_sub_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic        w_slt;
    logic [31:0] w_res;
    logic        w_carry;
    logic        w_ovf;
    logic [31:0] w_shift_next;

    // Opcode decode: the two immediate opcodes win over the funcode table.
    always_comb begin
        w_op = OP_NULL;
        if (opcode == 6'd1) begin
            w_op = OP_ADD;
        end else if (opcode == 6'd5) begin
            w_op = OP_COMP;
        end else begin
            case (opcode[3:0])
                4'd0:        w_op = OP_ADD;
                4'd2:        w_op = OP_COMP;
                4'd3:        w_op = OP_AND;
                4'd4:        w_op = OP_XOR;
                4'd11:       w_op = OP_SUB;
                4'd13:       w_op = OP_SLT;
                4'd6, 4'd8:  w_op = OP_SLL;
                4'd7, 4'd9:  w_op = OP_SRL;
                4'd10, 4'd12: w_op = OP_SRA;
                default:     w_op = OP_NULL;
            endcase
        end
    end

    // Shift amount always comes from the low five bits of operand 2,
    // for both the variable and the shamt encodings.
    assign w_shamt       = inp2[4:0];
    assign w_is_shift    = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);
    assign w_start_shift = w_is_shift && (w_shamt != 5'd0);

    // Shift direction/type captured into the FSM at acceptance.
    always_comb begin
        w_sh_type = SH_LL;
        case (w_op)
            OP_SRL:  w_sh_type = SH_RL;
            OP_SRA:  w_sh_type = SH_RA;
            default: w_sh_type = SH_LL;
        endcase
    end

    // Shared arithmetic: subtraction is inp1 plus the two's complement of
    // inp2; overflow uses the same sign rule on the actual addend.
    assign w_neg_b    = ~inp2 + 32'd1;
    assign w_add_sum  = {1'b0, inp1} + {1'b0, inp2};
    assign w_sub_diff = inp1 + w_neg_b;
    assign w_add_ovf  = (inp1[31] == inp2[31]) && (w_add_sum[31] != inp1[31]);
    assign w_sub_ovf  = (inp1[31] == w_neg_b[31]) && (w_sub_diff[31] != inp1[31]);
    assign w_slt      = $signed(inp1) < $signed(inp2);

    // Single-cycle result and flag selection; a zero-length shift passes
    // inp1 through unchanged.
    always_comb begin
        w_res   = 32'd0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res   = w_add_sum[31:0];
                w_carry = w_add_sum[32];
                w_ovf   = w_add_ovf;
            end
            OP_SUB: begin
                w_res = w_sub_diff;
                w_ovf = w_sub_ovf;
            end
            OP_COMP: w_res = w_neg_b;
            OP_AND:  w_res = inp1 & inp2;
            OP_XOR:  w_res = inp1 ^ inp2;
            OP_SLT:  w_res = {31'd0, w_slt};
            OP_SLL, OP_SRL, OP_SRA: w_res = inp1;
            default: w_res = 32'd0;
        endcase
    end

    // One-bit step of the shift register according to the captured type.
    always_comb begin
        w_shift_next = r_shreg;
        case (r_sh_type)
            SH_LL:   w_shift_next = {r_shreg[30:0], 1'b0};
            SH_RL:   w_shift_next = {1'b0, r_shreg[31:1]};
            SH_RA:   w_shift_next = {r_shreg[31], r_shreg[31:1]};
            default: w_shift_next = r_shreg;
        endcase
    end

    // Control FSM with registered result, flags, busy and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_result  <= 32'd0;
            r_zero    <= 1'b0;
            r_sign    <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_shreg   <= 32'd0;
            r_cnt     <= 5'd0;
            r_sh_type <= SH_LL;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_start_shift) begin
                            r_shreg   <= inp1;
                            r_cnt     <= w_shamt;
                            r_sh_type <= w_sh_type;
                            r_busy    <= 1'b1;
                            r_state   <= ST_SHIFT;
                        end else begin
                            r_result <= w_res;
                            r_zero   <= (w_res == 32'd0);
                            r_sign   <= w_res[31];
                            r_carry  <= w_carry;
                            r_ovf    <= w_ovf;
                            r_done   <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= w_shift_next;
                    r_cnt   <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == 32'd0);
                        r_sign   <= w_shift_next[31];
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign sign      = r_sign;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = (r_state == ST_SHIFT);

endmodule
